grant_lock: RTL
===============

# grant_lock

Registered grant stage that sits directly downstream of the combinational round-robin arbiter. It owns the round-robin `pointer` that the arbiter consumes and samples the arbiter's `chosen`/`given` outputs. It locks the winning port as a held grant until the winner releases, drops its request or exceeds a hold limit, then advances the pointer past the winner so the next arbitration is fair.

## Interface
- `number_ports`, default 4: number of requesters, ≥2; need not be a power of 2.
- `max_hold`, default 8: maximum cycles a grant may be held; 0 disables the watchdog.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset_n` input, 1 bit: reset is synchronous and active-low.
- `request` input, `number_ports` bits: raw request vector, the same vector that drives the arbiter.
- `chosen` input, `$clog2(number_ports)` bits: arbiter winner index.
- `given` input, 1 bit: arbiter valid, meaning at least one request is present.
- `release` input, 1 bit: current grant holder is finished, e.g. its tail has been transferred.
- `pointer` output, `$clog2(number_ports)` bits: registered round-robin priority pointer, fed to the arbiter.
- `grant_valid` output, 1 bit: a grant is held.
- `grant_idx` output, `$clog2(number_ports)` bits: index of the holder; it is 0 when `grant_valid`=0.
- `grant_onehot` output, `number_ports` bits: one-hot decode of `grant_idx`, gated by `grant_valid`.
- `timeout` output, 1 bit: one-cycle pulse when the watchdog forces a release.

## Operation
- Two states, `IDLE` and `LOCKED`.
- **Reset** (`reset_n`=0 at an edge):
  - state goes to `IDLE`; `pointer`=0; `grant_valid`=0; `grant_idx`=0; `grant_onehot`=0; `timeout`=0; hold counter=0.
  - Reset applied mid-grant drops the grant at that same edge, with no release side effects.
- **IDLE:**
  - A grant is accepted when `given`=1, `chosen` < `number_ports`, and `request[chosen]`=1.
  - On acceptance: go to `LOCKED`, `grant_idx`←`chosen`, counter←0.
  - A `given` that fails any of these checks is ignored, and the block stays in `IDLE`.
  - `pointer` does not change in `IDLE`.
- **LOCKED:** the grant ends when any of the following holds (release condition):
  - `release`=1;
  - `request[grant_idx]`=0;
  - `max_hold`≠0 and counter = `max_hold`−1.
- **Ending the grant:**
  - go to `IDLE`; `grant_valid`←0;
  - `pointer`←(`grant_idx`=`number_ports`−1) ? 0 : `grant_idx`+1, using a compare-based wrap, not a power-of-2 mask;
  - `timeout`←1 for one cycle only when the watchdog term alone caused the end.
- Otherwise the counter increments, saturating at `max_hold`−1.
- `chosen`/`given` are ignored in `LOCKED`; `grant_idx` never changes while locked.
- **Simultaneous events:**
  - `release` together with the watchdog term gives `timeout`=0, because release has priority for reporting.
  - Request drop together with `release` counts as a single end.
- **Counter width:** `$clog2(max_hold+1)`, minimum 1 bit.

## Timing
- **Grant latency:** `given` sampled at edge k gives `grant_valid`=1 from edge k onward, i.e. visible in cycle k+1.
- **Release latency:** release condition at edge k gives `grant_valid`=0 and the new `pointer` visible after edge k.
- Exactly one `IDLE` bubble cycle follows every grant end; the next grant is visible no earlier than edge k+1. This lets the arbiter re-evaluate with the updated pointer.
- **Minimum grant length** is 1 cycle, with release asserted in the first `LOCKED` cycle.
- **With `max_hold`=M:** a grant never lasts more than M cycles; `timeout` is high during the cycle after the forced end.
- All outputs are registered; nothing is combinational from inputs to outputs.

## Structure
- **Shared package `arb_pkg`:**
  - state enum `arb_state_t` {`IDLE`, `LOCKED`};
  - function `rr_next(idx, n)` returning the wrapped successor index, reused by other round-robin stages.
- **Sub-module `hold_timer`:**
  - parameters `max_hold`;
  - ports `clk`, `reset_n`, `clear`, `enable`, `expired`;
  - contains the saturating counter and the compare.
- The top contains the FSM, pointer register and one-hot decode.

## Test plan
- **Reset:** with N=4, M=8, drive `reset_n`=0 for 2 cycles with `request`=4'b1111 → all outputs 0 and `pointer`=0 throughout.
- **Fair rotation:**
  - `request`=4'b1111, `release` pulsed every 3rd `LOCKED` cycle → `grant_idx` sequence 0,1,2,3,0.
  - `pointer` sequence after each end: 1,2,3,0.
  - One `IDLE` cycle between grants.
- **Wrap / non-power-of-2:** with N=3, `request`=3'b100, `pointer`=2 → grant to 2; after release `pointer`=0; `grant_onehot`=3'b100 while locked.
- **Watchdog:**
  - M=8, `request`=4'b0010 held with no release → `grant_valid` high exactly 8 cycles, then `timeout` pulses 1 cycle, `pointer`=2.
  - Same run with `release` asserted on the 8th cycle → `timeout` stays 0.
- **Request drop and bogus given:**
  - Holder 1 deasserts `request[1]` → grant ends next edge, `pointer`=2.
  - In `IDLE`, force `given`=1 with `chosen`=3 and `request`=4'b0001 → no grant.
- **Reset mid-grant:** `reset_n`=0 in the 2nd `LOCKED` cycle of holder 2 → next cycle `grant_valid`=0, `pointer`=0 (not 3), `timeout`=0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the round-robin arbitration stages.
package arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    // Compare-based wrap so non-power-of-2 port counts rotate correctly.
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/grant_lock_timer.sv
// hold_timer: saturating hold counter that flags when a grant reaches its hold limit.
module hold_timer #(
    parameter int max_hold = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int cw = (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    localparam logic [cw-1:0] last = cw'((max_hold == 0) ? 0 : max_hold - 1);

    logic [cw-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear)
            count <= '0;
        else if (enable && count != last)
            count <= count + 1'b1;
    end

    // A zero limit disables the watchdog entirely.
    assign expired = (max_hold != 0) && (count == last);

endmodule

// File: rtl/grant_lock.sv
// grant_lock: registered grant stage that locks the arbiter winner and
// advances the round-robin pointer past it when the grant ends.
module grant_lock
    import arb_pkg::*;
#(
    parameter int number_ports = 4,
    parameter int max_hold     = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [number_ports-1:0]         request,
    input  logic [$clog2(number_ports)-1:0] chosen,
    input  logic                            given,
    input  logic                            release_grant,
    output logic [$clog2(number_ports)-1:0] pointer,
    output logic                            grant_valid,
    output logic [$clog2(number_ports)-1:0] grant_idx,
    output logic [number_ports-1:0]         grant_onehot,
    output logic                            timeout
);

    localparam int w = $clog2(number_ports);

    arb_state_t state, state_next;
    logic accept, rel_hit, expired, end_grant;

    assign accept    = given && (int'(chosen) < number_ports) && request[chosen];
    assign rel_hit   = release_grant || !request[grant_idx];
    assign end_grant = rel_hit || expired;

    hold_timer #(.max_hold(max_hold)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == IDLE),
        .enable  (state == LOCKED),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            pointer   <= '0;
            grant_idx <= '0;
            timeout   <= 1'b0;
        end else begin
            state   <= state_next;
            // Release and request drop take reporting priority over the watchdog.
            timeout <= (state == LOCKED) && !rel_hit && expired;
            if (state == IDLE && accept)
                grant_idx <= chosen;
            else if (state == LOCKED && end_grant) begin
                grant_idx <= '0;
                pointer   <= w'(rr_next(int'(grant_idx), number_ports));
            end
        end
    end

    always_comb begin
        state_next = (state == IDLE) ? (accept ? LOCKED : IDLE) : (end_grant ? IDLE : LOCKED);
    end

    always_comb begin
        grant_valid  = (state == LOCKED);
        grant_onehot = grant_valid ? (number_ports'(1) << grant_idx) : '0;
    end

endmodule
